edge_link_array: RTL and testbench

//  Parametrised, buffered edge link between the I/O bridges and the switch ring of the overlay.

---
 rtl/edge_link_array.sv | 105 ++++++++++
 tb/tb_edge_link_array.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_link_array.sv
// Buffered, credit-flow-controlled edge link: NUM_CH independent channels, each with
// a FIFO, a downstream credit counter and a serially configured enable bit.
module edge_link_array #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int CREDITS = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           conf_en,
   input  logic                           conf_in,
   output logic                           conf_out,
   input  logic [NUM_CH*(DATA_W+1)-1:0]   d_in,
   output logic [NUM_CH-1:0]              c_out,
   output logic [NUM_CH*(DATA_W+1)-1:0]   d_out,
   input  logic [NUM_CH-1:0]              c_in,
   output logic [NUM_CH-1:0]              ovf
);

   localparam int W  = DATA_W + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int KW = $clog2(CREDITS + 1);

   logic [NUM_CH-1:0] mask;
   logic [NUM_CH:0]   mask_shift;

   // Shifting through a one-bit-wider vector keeps NUM_CH == 1 legal.
   assign mask_shift = {mask, conf_in};
   assign conf_out   = mask[NUM_CH-1];

   always_ff @(posedge clk) begin
      if (rst)
         mask <= '1;
      else if (conf_en)
         mask <= mask_shift[NUM_CH-1:0];
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PW-1:0]     rd_ptr;
      logic [PW-1:0]     wr_ptr;
      logic [CW-1:0]     count;
      logic [KW-1:0]     credit;
      logic [W-1:0]      dout_r;
      logic              cout_r;
      logic              ovf_r;
      logic              in_valid;
      logic              en;
      logic              pop;
      logic              wr;
      logic              accept;
      logic              discard;

      always_comb begin
         in_valid = d_in[k*W + DATA_W];
         en       = mask[k];
         pop      = en && (count != '0) && (credit != '0) && !conf_en;
         wr       = en && in_valid;
         // A full FIFO still takes the word when the same edge frees a slot.
         accept   = wr && ((count < CW'(DEPTH)) || pop);
         discard  = !en && in_valid;
      end

      always_ff @(posedge clk) begin
         if (accept)
            mem[wr_ptr] <= d_in[k*W +: DATA_W];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            credit <= KW'(CREDITS);
            dout_r <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
         end else begin
            if (accept)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            if (pop && !c_in[k])
               credit <= credit - KW'(1);
            else if (c_in[k] && !pop && (credit != KW'(CREDITS)))
               credit <= credit + KW'(1);
            dout_r <= pop ? {1'b1, mem[rd_ptr]} : '0;
            cout_r <= pop || discard;
            ovf_r  <= ovf_r || (wr && !accept);
         end
      end

      assign d_out[k*W +: W] = dout_r;
      assign c_out[k]        = cout_r;
      assign ovf[k]          = ovf_r;
   end

endmodule

// File: tb/tb_edge_link_array.sv
// Directed bench for edge_link_array: a queue-based reference model pushes expected
// outputs per cycle; they are popped and compared after each clock edge.
module tb_edge_link_array;

   localparam int NC = 4;
   localparam int W  = 33;
   localparam int TW = NC * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          conf_en = 1'b0;
   logic          conf_in = 1'b0;
   logic          conf_out;
   logic [TW-1:0] d_in = '0;
   logic [NC-1:0] c_out;
   logic [TW-1:0] d_out;
   logic [NC-1:0] c_in = '0;
   logic [NC-1:0] ovf;

   edge_link_array #(.NUM_CH(4), .DATA_W(32), .DEPTH(4), .CREDITS(2)) dut (
      .clk(clk), .rst(rst), .conf_en(conf_en), .conf_in(conf_in), .conf_out(conf_out),
      .d_in(d_in), .c_out(c_out), .d_out(d_out), .c_in(c_in), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TW-1:0] dout;
      logic [NC-1:0] cout;
      logic [NC-1:0] ovf;
      logic          conf;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mq [NC][$];
   int          mcred [NC];
   logic [NC-1:0] mmask;
   logic [NC-1:0] movf;
   int          checks = 0;
   int          fails  = 0;
   int          nvalid;

   task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [TW-1:0] w(input int ch, input logic [31:0] data);
      logic [TW-1:0] r;
      r = '0;
      r[ch*W +: W] = {1'b1, data};
      return r;
   endfunction

   task automatic step(input logic [TW-1:0] din, input logic [NC-1:0] cin,
                       input logic cen, input logic cbit, input logic r);
      exp_t e;
      d_in = din; c_in = cin; conf_en = cen; conf_in = cbit; rst = r;
      e = '0;
      if (r) begin
         for (int k = 0; k < NC; k++) begin
            mq[k].delete();
            mcred[k] = 2;
         end
         mmask = '1;
         movf  = '0;
      end else begin
         for (int k = 0; k < NC; k++) begin
            logic v, p, room;
            v    = din[k*W + 32];
            p    = mmask[k] && (mq[k].size() > 0) && (mcred[k] > 0) && !cen;
            room = (mq[k].size() < 4) || p;
            if (p) begin
               e.dout[k*W +: W] = {1'b1, mq[k].pop_front()};
               e.cout[k] = 1'b1;
            end
            if (!mmask[k] && v)
               e.cout[k] = 1'b1;
            if (mmask[k] && v) begin
               if (room) mq[k].push_back(din[k*W +: 32]);
               else      movf[k] = 1'b1;
            end
            if (p && !cin[k])
               mcred[k]--;
            else if (cin[k] && !p && mcred[k] < 2)
               mcred[k]++;
         end
         if (cen)
            mmask = {mmask[NC-2:0], cbit};
      end
      e.ovf  = movf;
      e.conf = mmask[NC-1];
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_dout", d_out, e.dout);
      chk("sb_cout", TW'(c_out), TW'(e.cout));
      chk("sb_ovf", TW'(ovf), TW'(e.ovf));
      chk("sb_conf", TW'(conf_out), TW'(e.conf));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_count(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         step('0, '0, 1'b0, 1'b0, 1'b0);
         if (d_out[ch*W + 32]) nvalid++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset, then single word on ch0 with two-cycle latency
      step('0, '0, 1'b0, 1'b0, 1'b1);
      chk("rst_dout", d_out, '0);
      chk("rst_conf", TW'(conf_out), TW'(1'b1));
      step(w(0, 32'hDEADBEEF), '0, 1'b0, 1'b0, 1'b0);
      chk("t1_not_yet", TW'(d_out[32]), TW'(1'b0));
      idle(1);
      chk("t1_dout", TW'(d_out[32:0]), TW'(33'h1DEADBEEF));
      chk("t1_cout", TW'(c_out[0]), TW'(1'b1));
      idle(1);
      chk("t1_one_cycle", TW'(d_out[32:0]), '0);

      // 2: four words on ch1 with only two credits
      nvalid = 0;
      for (int i = 0; i < 4; i++) begin
         step(w(1, 32'hA000_0001 + i), '0, 1'b0, 1'b0, 1'b0);
         if (d_out[W + 32]) nvalid++;
      end
      idle_count(1, 3);
      chk("t2_out_count", TW'(nvalid), TW'(2));
      step('0, 4'b0010, 1'b0, 1'b0, 1'b0);
      chk("t2_cin_edge", TW'(d_out[W + 32]), TW'(1'b0));
      idle(1);
      chk("t2_third", TW'(d_out[W +: W]), TW'({1'b1, 32'hA000_0003}));

      // 3: overflow on ch2 once credits are exhausted
      step(w(2, 32'hB1), '0, 1'b0, 1'b0, 1'b0);
      step(w(2, 32'hB2), '0, 1'b0, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < 4; i++) step(w(2, 32'hC1 + i), '0, 1'b0, 1'b0, 1'b0);
      chk("t3_full_no_ovf", TW'(ovf[2]), TW'(1'b0));
      step(w(2, 32'hC5), '0, 1'b0, 1'b0, 1'b0);
      chk("t3_ovf", TW'(ovf[2]), TW'(1'b1));
      idle(1);
      chk("t3_sticky", TW'(ovf[2]), TW'(1'b1));
      step('0, '0, 1'b0, 1'b0, 1'b1);
      chk("t3_ovf_rst", TW'(ovf), '0);
      step(w(2, 32'hD1), '0, 1'b0, 1'b0, 1'b0);
      step(w(2, 32'hD2), '0, 1'b0, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < 3; i++) step(w(2, 32'hE1 + i), '0, 1'b0, 1'b0, 1'b0);
      step(w(2, 32'hE4), 4'b0100, 1'b0, 1'b0, 1'b0);
      step(w(2, 32'hE5), '0, 1'b0, 1'b0, 1'b0);
      chk("t3_pop_in_full", TW'(d_out[2*W +: W]), TW'({1'b1, 32'hE1}));
      chk("t3_no_ovf", TW'(ovf[2]), TW'(1'b0));

      // 4: config chain, ch2 disabled
      step('0, '0, 1'b0, 1'b0, 1'b1);
      step('0, '0, 1'b1, 1'b1, 1'b0);
      step('0, '0, 1'b1, 1'b0, 1'b0);
      step('0, '0, 1'b1, 1'b1, 1'b0);
      step('0, '0, 1'b1, 1'b1, 1'b0);
      step(w(2, 32'hF1) | w(0, 32'hF0), '0, 1'b0, 1'b0, 1'b0);
      chk("t4_disc_cout", TW'(c_out[2]), TW'(1'b1));
      chk("t4_disc_dout", TW'(d_out[2*W +: W]), '0);
      idle(1);
      chk("t4_en_ch0", TW'(d_out[32:0]), TW'({1'b1, 32'hF0}));
      chk("t4_disc_dout2", TW'(d_out[2*W +: W]), '0);
      chk("t4_no_ovf", TW'(ovf), '0);
      step('0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_conf_out", TW'(conf_out), TW'(1'b0));

      // 5: pop with simultaneous c_in keeps credit, saturation at CREDITS
      step('0, '0, 1'b0, 1'b0, 1'b1);
      step(w(3, 32'h61), '0, 1'b0, 1'b0, 1'b0);
      idle(1);
      step(w(3, 32'h62), '0, 1'b0, 1'b0, 1'b0);
      step(w(3, 32'h63), 4'b1000, 1'b0, 1'b0, 1'b0);
      chk("t5_g2", TW'(d_out[3*W +: W]), TW'({1'b1, 32'h62}));
      idle(1);
      chk("t5_g3", TW'(d_out[3*W +: W]), TW'({1'b1, 32'h63}));
      nvalid = 0;
      step(w(3, 32'h64), '0, 1'b0, 1'b0, 1'b0);
      idle_count(3, 2);
      chk("t5_credit_zero", TW'(nvalid), TW'(0));
      step('0, '0, 1'b0, 1'b0, 1'b1);
      step('0, 4'b1000, 1'b0, 1'b0, 1'b0);
      step('0, 4'b1000, 1'b0, 1'b0, 1'b0);
      nvalid = 0;
      for (int i = 0; i < 3; i++) begin
         step(w(3, 32'h71 + i), '0, 1'b0, 1'b0, 1'b0);
         if (d_out[3*W + 32]) nvalid++;
      end
      idle_count(3, 3);
      chk("t5_saturate", TW'(nvalid), TW'(2));

      // 6: reset discards buffered words
      step('0, '0, 1'b0, 1'b0, 1'b1);
      step(w(0, 32'h81), '0, 1'b0, 1'b0, 1'b0);
      step(w(0, 32'h82), '0, 1'b0, 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < 3; i++) step(w(0, 32'h83 + i), '0, 1'b0, 1'b0, 1'b0);
      idle(1);
      step('0, '0, 1'b0, 1'b0, 1'b1);
      chk("t6_dout", d_out, '0);
      chk("t6_cout", TW'(c_out), '0);
      nvalid = 0;
      step('0, 4'b0001, 1'b0, 1'b0, 1'b0);
      if (d_out[32]) nvalid++;
      idle_count(0, 3);
      chk("t6_no_stale", TW'(nvalid), TW'(0));
      nvalid = 0;
      for (int i = 0; i < 3; i++) begin
         step(w(0, 32'h91 + i), '0, 1'b0, 1'b0, 1'b0);
         if (d_out[32]) nvalid++;
      end
      idle_count(0, 3);
      chk("t6_credits", TW'(nvalid), TW'(2));

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
